// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared constants for the count sequencer
//
// Purpose: state encodings, default widths and parameter minimums shared by
//          count_sequencer and button_debounce.
// Ports:   none (package).
// Config:  COUNT_SEQ_AUTO_REPEAT_EN (used by count_sequencer only).

package count_seq_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN_FWD = 2'd1;
  localparam logic [1:0] RUN_BWD = 2'd2;

  // Default LED bus width
  localparam int LED_W_DEFAULT = 5;

  // Smallest meaningful parameter values: the debouncer needs at least two
  // stable samples, and a run phase must outlast one counter pass (~34 cycles).
  localparam int DEBOUNCE_MIN = 2;
  localparam int TIMEOUT_MIN  = 40;

  // True for any state in which a counter is running
  function automatic logic is_run(input logic [1:0] state);
    return state != IDLE;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button synchroniser, debouncer and press detector
//
// Purpose: brings the raw button into the clock domain, accepts a new level only
//          after it has been stable for DEBOUNCE_CYCLES cycles, and emits a
//          one-cycle press pulse on each accepted 0->1 transition.
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high
//   button  in   raw asynchronous push-button, active-high
//   press   out  one-cycle pulse on accepted rising level (registered)

module button_debounce
  import count_seq_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic        sync1_q,  sync1_d;
  logic        sync2_q,  sync2_d;
  logic        stable_q, stable_d;
  logic [15:0] cnt_q,    cnt_d;
  logic        press_q,  press_d;

  always_comb begin
    sync1_d  = button;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = 16'd0;
    press_d  = 1'b0;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreement (a bounce back) restarts it from zero.
    if (sync2_q != stable_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        stable_d = sync2_q;
        // Only the rising level produces a press; releases are silent.
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= 16'd0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - sequences the forward then backward LED counter
//
// Purpose: on a debounced button press, starts the forward counter, waits for
//          its completion pulse, starts the backward counter, waits for its
//          completion pulse, then returns to idle. A per-phase watchdog aborts
//          a phase whose counter never completes and raises a sticky error.
//          The active counter's LED value is registered onto led_out.
// Config:  COUNT_SEQ_AUTO_REPEAT_EN - when defined, the forward/backward pair
//          repeats until a press during a run requests a stop, which takes
//          effect at the next backward completion.
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-high
//   button    in   raw push-button, active-high
//   next_fwd  in   completion pulse from the forward counter
//   next_bwd  in   completion pulse from the backward counter
//   led_fwd   in   forward counter LED value
//   led_bwd   in   backward counter LED value
//   go_fwd    out  one-cycle start pulse to the forward counter
//   go_bwd    out  one-cycle start pulse to the backward counter
//   led_out   out  registered LED drive
//   busy      out  high in any run state
//   error     out  sticky timeout flag, cleared by the next accepted press

module count_sequencer
  import count_seq_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  TIMEOUT_CYCLES  = 8'd96,
  parameter int          LED_W           = LED_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             button,
  input  logic             next_fwd,
  input  logic             next_bwd,
  input  logic [LED_W-1:0] led_fwd,
  input  logic [LED_W-1:0] led_bwd,
  output logic             go_fwd,
  output logic             go_bwd,
  output logic [LED_W-1:0] led_out,
  output logic             busy,
  output logic             error
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 8'd1);

  logic press;

  logic [1:0]       state_q,  state_d;
  logic [TW-1:0]    timer_q,  timer_d;
  logic             go_fwd_q, go_fwd_d;
  logic             go_bwd_q, go_bwd_d;
  logic [LED_W-1:0] led_q,    led_d;
  logic             busy_q,   busy_d;
  logic             error_q,  error_d;
`ifdef COUNT_SEQ_AUTO_REPEAT_EN
  logic             stop_req_q, stop_req_d;
`endif

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .button (button),
    .press  (press)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    go_fwd_d = 1'b0;
    go_bwd_d = 1'b0;
    led_d    = led_q;
    error_d  = error_q;
`ifdef COUNT_SEQ_AUTO_REPEAT_EN
    stop_req_d = stop_req_q;
`endif

    // LED mux follows the state being left, giving one cycle of latency.
    // In IDLE the last displayed value is held.
    if (state_q == RUN_FWD) begin
      led_d = led_fwd;
    end else if (state_q == RUN_BWD) begin
      led_d = led_bwd;
    end

    case (state_q)
      IDLE: begin
        if (press) begin
          state_d  = RUN_FWD;
          go_fwd_d = 1'b1;
          error_d  = 1'b0;
          timer_d  = '0;
        end
      end

      RUN_FWD: begin
        // Completion is checked before the watchdog so a next pulse on the
        // final allowed cycle still counts as success.
        if (next_fwd) begin
          state_d  = RUN_BWD;
          go_bwd_d = 1'b1;
          timer_d  = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = IDLE;
          error_d = 1'b1;
          timer_d = '0;
        end else begin
          // TIMER_LAST fits in TW bits, so this increment can never wrap.
          timer_d = timer_q + TW'(1);
        end
      end

      RUN_BWD: begin
        if (next_bwd) begin
          timer_d = '0;
`ifdef COUNT_SEQ_AUTO_REPEAT_EN
          // A press in this same cycle also counts as a stop request.
          if (stop_req_q || press) begin
            state_d = IDLE;
          end else begin
            state_d  = RUN_FWD;
            go_fwd_d = 1'b1;
          end
`else
          state_d = IDLE;
`endif
        end else if (timer_q == TIMER_LAST) begin
          state_d = IDLE;
          error_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

`ifdef COUNT_SEQ_AUTO_REPEAT_EN
    if (is_run(state_q) && press) begin
      stop_req_d = 1'b1;
    end
    // Every way back to IDLE (stop or timeout) retires the request.
    if (state_d == IDLE) begin
      stop_req_d = 1'b0;
    end
`endif

    busy_d = is_run(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      go_fwd_q <= 1'b0;
      go_bwd_q <= 1'b0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef COUNT_SEQ_AUTO_REPEAT_EN
      stop_req_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      go_fwd_q <= go_fwd_d;
      go_bwd_q <= go_bwd_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
`ifdef COUNT_SEQ_AUTO_REPEAT_EN
      stop_req_q <= stop_req_d;
`endif
    end
  end

  assign go_fwd  = go_fwd_q;
  assign go_bwd  = go_bwd_q;
  assign led_out = led_q;
  assign busy    = busy_q;
  assign error   = error_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - self-checking bench for count_sequencer

module tb_count_sequencer;

  localparam int DEB = 4;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic       next_fwd = 1'b0;
  logic       next_bwd = 1'b0;
  logic [4:0] led_fwd = 5'd0;
  logic [4:0] led_bwd = 5'd0;
  logic       go_fwd, go_bwd, busy, error;
  logic [4:0] led_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_sequencer #(
    .DEBOUNCE_CYCLES (16'd4),
    .TIMEOUT_CYCLES  (8'd64),
    .LED_W           (5)
  ) dut (
    .clock    (clk),
    .reset    (reset),
    .button   (button),
    .next_fwd (next_fwd),
    .next_bwd (next_bwd),
    .led_fwd  (led_fwd),
    .led_bwd  (led_bwd),
    .go_fwd   (go_fwd),
    .go_bwd   (go_bwd),
    .led_out  (led_out),
    .busy     (busy),
    .error    (error)
  );

  // Reference model: phase-level behaviour, button delay line as a queue,
  // and a count of consecutive samples that disagree with the accepted level.
  typedef enum int {P_IDLE, P_FWD, P_BWD} phase_t;
  phase_t     m_phase = P_IDLE;
  int         m_age = 0;
  int         m_run = 0;
  bit         m_go_f = 0, m_go_b = 0, m_err = 0, m_press = 0, m_stable = 0, m_stop = 0;
  logic [4:0] m_led = 5'd0;
  bit         hist[$] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    phase_t was;
    bit     synced;
    bit     done;
    if (reset) begin
      m_phase = P_IDLE; m_age = 0; m_run = 0;
      m_go_f = 0; m_go_b = 0; m_err = 0; m_press = 0; m_stable = 0; m_stop = 0;
      m_led = 5'd0;
      hist = '{1'b0, 1'b0};
    end else begin
      was = m_phase;
      m_go_f = 0;
      m_go_b = 0;
      if (was == P_FWD) m_led = led_fwd;
      else if (was == P_BWD) m_led = led_bwd;
      if (was == P_IDLE) begin
        if (m_press) begin
          m_phase = P_FWD; m_go_f = 1; m_err = 0; m_age = 0;
        end
      end else begin
`ifdef COUNT_SEQ_AUTO_REPEAT_EN
        if (m_press) m_stop = 1;
`endif
        done = (was == P_FWD) ? next_fwd : next_bwd;
        if (done) begin
          m_age = 0;
          if (was == P_FWD) begin
            m_phase = P_BWD; m_go_b = 1;
          end else begin
`ifdef COUNT_SEQ_AUTO_REPEAT_EN
            if (m_stop) m_phase = P_IDLE;
            else begin m_phase = P_FWD; m_go_f = 1; end
`else
            m_phase = P_IDLE;
`endif
          end
        end else if (m_age == TO - 1) begin
          m_phase = P_IDLE; m_err = 1;
        end else begin
          m_age++;
        end
        if (m_phase == P_IDLE) m_stop = 0;
      end
      synced = hist.pop_front();
      hist.push_back(button);
      m_press = 0;
      if (synced != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = synced; m_press = synced; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare all outputs against the model, then refresh LED inputs.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("go_fwd", go_fwd, m_go_f);
    check("go_bwd", go_bwd, m_go_b);
    check("go_excl", go_fwd & go_bwd, 0);
    check("busy", busy, m_phase != P_IDLE);
    check("error", error, m_err);
    check("led_out", led_out, m_led);
    led_fwd = 5'($urandom_range(0, 31));
    led_bwd = 5'($urandom_range(0, 31));
  endtask

  task automatic press_and_wait(input string tag);
    bit seen = 0;
    button = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = go_fwd;
    end
    button = 1'b0;
    check(tag, seen, 1);
  endtask

  int lat, pulses, f_cnt, f_d, b_cnt, b_d, hold;
  logic [4:0] lb;

  initial begin
    tick(); tick();
    check("rst_led", led_out, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Held press: single go_fwd, 7 cycles after the button rises
    button = 1'b1; lat = 0; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulses == 0) lat++;
      if (go_fwd) pulses++;
    end
    button = 1'b0;
    check("press_latency", lat, 7);
    check("press_pulses", pulses, 1);
    check("press_busy", busy, 1);
    reset = 1'b1; tick(); reset = 1'b0;

    // Bounce: no press
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      button = (i < 4) ? ((i % 2) == 0) : 1'b0;
      tick();
      if (go_fwd || go_bwd) pulses++;
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_idle", busy, 0);

    // Full pass with 34-cycle counters
    press_and_wait("pass_go_fwd");
    for (int i = 0; i < 34; i++) tick();
    next_fwd = 1'b1; tick(); next_fwd = 1'b0;
    check("pass_go_bwd", go_bwd, 1);
    for (int i = 0; i < 33; i++) tick();
    lb = led_bwd;
    next_bwd = 1'b1; tick(); next_bwd = 1'b0;
    check("pass_led_last", led_out, lb);
`ifndef COUNT_SEQ_AUTO_REPEAT_EN
    check("pass_idle", busy, 0);
    for (int i = 0; i < 5; i++) tick();
    check("pass_led_hold", led_out, lb);
`else
    check("pass_repeat", go_fwd, 1);
    reset = 1'b1; tick(); reset = 1'b0;
`endif

    // Timeout in RUN_FWD
    press_and_wait("to_go_fwd");
    pulses = 0;
    for (int i = 0; i < 63; i++) begin tick(); if (go_bwd) pulses++; end
    check("to_still_busy", busy, 1);
    tick();
    check("to_idle", busy, 0);
    check("to_error", error, 1);
    check("to_no_bwd", pulses, 0);
    for (int i = 0; i < 4; i++) tick();
    press_and_wait("to_repress");
    check("to_err_clear", error, 0);

    // Stray press and next_bwd during RUN_FWD, next_fwd on final cycle
    for (int i = 1; i <= 63; i++) begin
      button   = (i >= 5 && i < 13);
      next_bwd = (i == 20 || i == 40);
      tick();
    end
    button = 1'b0; next_bwd = 1'b0;
    check("late_still_fwd", busy, 1);
    next_fwd = 1'b1; tick(); next_fwd = 1'b0;
    check("late_go_bwd", go_bwd, 1);
    check("late_no_err", error, 0);

    // Reset mid RUN_BWD
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_led", led_out, 0);
    check("mid_rst_go", {go_fwd, go_bwd, error}, 0);

    // Randomised traffic with emulated counters
    f_d = -1; b_d = -1; f_cnt = 0; b_cnt = 0; hold = 0;
    for (int i = 0; i < 5000; i++) begin
      if (go_fwd) begin f_cnt = 0; f_d = $urandom_range(20, 70); end
      if (go_bwd) begin b_cnt = 0; b_d = $urandom_range(20, 70); end
      next_fwd = (f_d >= 0 && f_cnt == f_d) || ($urandom_range(0, 59) == 0);
      next_bwd = (b_d >= 0 && b_cnt == b_d) || ($urandom_range(0, 59) == 0);
      if (f_d >= 0 && f_cnt == f_d) f_d = -1;
      if (b_d >= 0 && b_cnt == b_d) b_d = -1;
      f_cnt++; b_cnt++;
      if (hold > 0) begin
        hold--; button = 1'b1;
      end else begin
        button = 1'b0;
        if ($urandom_range(0, 39) == 0) hold = $urandom_range(1, 10);
      end
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0; next_fwd = 1'b0; next_bwd = 1'b0; button = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Upstream control stage for the up/down LED counter pair.
- Debounces the raw "go" push-button.
- Fires the forward counter, then the backward counter, using each counter's one-cycle `next` completion pulse as the handshake.
- Muxes the active counter's 5-bit LED value onto the board LEDs; a watchdog recovers from a counter that never completes.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000 — cycles the synchronised button must be stable before a new level is accepted (min 2).
- TIMEOUT_CYCLES, 8'd96 — max cycles a run phase may last before abort (min 40; a counter pass is about 34 cycles).
- LED_W, 5 — LED bus width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the clock edge where reset=1
- button  in  1  raw asynchronous push-button, active-high
- next_fwd  in  1  completion pulse from the forward counter
- next_bwd  in  1  completion pulse from the backward counter
- led_fwd  in  LED_W  forward counter LED value
- led_bwd  in  LED_W  backward counter LED value
- go_fwd  out  1  one-cycle start pulse to the forward counter
- go_bwd  out  1  one-cycle start pulse to the backward counter
- led_out  out  LED_W  registered LED drive
- busy  out  1  high in any run state
- error  out  1  sticky timeout flag

Behaviour:
- Reset values: go_fwd=0, go_bwd=0, led_out=0, busy=0, error=0, state=IDLE, debounce stable level=0, all counters=0.
- Debounce:
  - 2-flop synchroniser on `button`.
  - Counter runs while synced != stable and clears when they are equal.
  - At count DEBOUNCE_CYCLES-1, stable <= synced.
  - `press` = one-cycle pulse on stable 0->1; release edges are ignored.
- States: IDLE, RUN_FWD, RUN_BWD.
- IDLE:
  - On press: state <= RUN_FWD, go_fwd <= 1, error <= 0, timer <= 0.
- RUN_FWD:
  - On next_fwd: state <= RUN_BWD, go_bwd <= 1, timer <= 0.
  - Otherwise timer increments; at TIMEOUT_CYCLES-1: state <= IDLE, error <= 1.
- RUN_BWD:
  - On next_bwd: state <= IDLE.
  - Timer and timeout handling identical to RUN_FWD.
- go_fwd and go_bwd are high for exactly one cycle: the first cycle of the new state. They are never high together.
- busy = (state != IDLE), registered with state.
- led_out: registered, 1-cycle latency. Value is led_fwd in RUN_FWD, led_bwd in RUN_BWD, and held at its last value in IDLE (only reset clears it).
- Boundary rules:
  - Press in RUN_FWD or RUN_BWD: ignored.
  - A `next` for the non-active counter: ignored.
  - `next` and timeout in the same cycle: `next` wins, no error.
  - Press and reset in the same cycle: reset wins.
  - Reset mid-run: immediate return to IDLE with outputs at reset values. The counters share reset, so no handshake cleanup is needed.
- Timer width is $clog2(TIMEOUT_CYCLES); the timer saturates and never wraps.

Optional Feature:
- Macro: COUNT_SEQ_AUTO_REPEAT_EN.
- Defined:
  - next_bwd in RUN_BWD -> RUN_FWD with go_fwd pulse.
  - Sequence repeats indefinitely.
  - A press during a run sets a stop_req flag. The next next_bwd then goes to IDLE and clears stop_req.
  - Timeout still aborts to IDLE and clears stop_req.
- Undefined: single forward+backward pass per press, exactly as above. stop_req logic is absent.

Decomposition:
- Package count_seq_pkg:
  - state enum/localparams: IDLE=2'd0, RUN_FWD=2'd1, RUN_BWD=2'd2
  - LED_W default
  - minimum-value constants for DEBOUNCE_CYCLES and TIMEOUT_CYCLES
- Sub-module button_debounce (params DEBOUNCE_CYCLES; ports clock, reset, button, press): contains the synchroniser, stability counter and edge detect.
- Top-level holds the FSM, timer and LED mux.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64):
- Hold button high 20 cycles -> exactly one go_fwd pulse, 7 cycles after button rises (2 sync + 4 stable + 1); busy=1.
- Bounce button 1,0,1,0 on single cycles, then stay low -> no press, no go pulses, state IDLE.
- Press; drive next_fwd 34 cycles after go_fwd; drive next_bwd 34 cycles after go_bwd -> go_bwd one cycle after next_fwd, then IDLE, busy=0. led_out tracks led_fwd then led_bwd with 1-cycle lag and holds the last value.
- Press; never drive next_fwd -> at cycle 63 after go_fwd, state IDLE, error=1, no go_bwd. Next press clears error and emits go_fwd.
- Second press and next_bwd pulses during RUN_FWD -> ignored; next_fwd and timeout coincident at cycle 63 -> RUN_BWD, error=0.
- Reset asserted mid-RUN_BWD -> next cycle all outputs 0, state IDLE. With COUNT_SEQ_AUTO_REPEAT_EN: three passes complete, then a press ends the run after the current next_bwd.
